// File: rtl/mac_share_scheduler.sv
// Round-robin time-sharing of one MAC between two requesters.
// Each granted job runs: clear, coefficient rewind, N paired reads, drain, load, done.
//
// state  | meaning
// IDLE   | no job; arbitrate requests (skipped in the cycle right after DONE)
// CLEAR  | accumulator clear and coefficient-pointer rewind
// STREAM | paired FIFO reads until count reaches the latched length
// DRAIN  | PIPE_LAT cycles for the last product to reach the accumulator
// LOAD   | result-register load strobe
// DONE   | completion pulse to the owner, ownership released
module mac_share_scheduler #(
  parameter int ADDR_LINES = 4,
  parameter int LEN_WIDTH  = 5,
  parameter int PIPE_LAT   = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [1:0]           req_i,
  input  logic [LEN_WIDTH-1:0] len0_i,
  input  logic [LEN_WIDTH-1:0] len1_i,
  input  logic                 empty_signal_i,
  input  logic                 empty_coeff_i,
  output logic [1:0]           grant_o,
  output logic                 busy_o,
  output logic                 rd_en_signal_o,
  output logic                 rd_en_coeff_o,
  output logic                 redo_coeff_o,
  output logic                 acc_clr_n_o,
  output logic                 ld_result_o,
  output logic [1:0]           done_o
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_LINES);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, STREAM, DRAIN, LOAD, DONE
  } state_t;

  state_t               state;
  logic                 last_grant;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] count;
  logic [DW-1:0]        drain_cnt;

  logic                 pick;
  logic [LEN_WIDTH-1:0] sel_len;
  logic [LEN_WIDTH-1:0] clamped_len;
  logic [LEN_WIDTH-1:0] count_nxt;
  logic                 fire;

  always_comb begin
    pick = 1'b0;
    if (req_i == 2'b11) pick = ~last_grant;
    else                pick = req_i[1];
    sel_len     = pick ? len1_i : len0_i;
    clamped_len = (sel_len > MAX_LEN) ? MAX_LEN : sel_len;
    count_nxt   = count + LEN_WIDTH'(1);
    fire        = (count < len_q) && !empty_signal_i && !empty_coeff_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      len_q          <= '0;
      count          <= '0;
      drain_cnt      <= '0;
      grant_o        <= 2'b00;
      busy_o         <= 1'b0;
      rd_en_signal_o <= 1'b0;
      rd_en_coeff_o  <= 1'b0;
      redo_coeff_o   <= 1'b0;
      acc_clr_n_o    <= 1'b0;
      ld_result_o    <= 1'b0;
      done_o         <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          acc_clr_n_o    <= 1'b1;
          done_o         <= 2'b00;
          ld_result_o    <= 1'b0;
          redo_coeff_o   <= 1'b0;
          rd_en_signal_o <= 1'b0;
          rd_en_coeff_o  <= 1'b0;
          // busy_o still high means done_o is on the wire; the owner may not
          // have dropped its request yet, so hold off arbitration one cycle.
          if (busy_o) begin
            busy_o  <= 1'b0;
            grant_o <= 2'b00;
          end else if (req_i != 2'b00) begin
            grant_o    <= pick ? 2'b10 : 2'b01;
            busy_o     <= 1'b1;
            last_grant <= pick;
            len_q      <= clamped_len;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          acc_clr_n_o  <= 1'b0;
          redo_coeff_o <= 1'b1;
          count        <= '0;
          drain_cnt    <= DW'(PIPE_LAT - 1);
          state        <= (len_q == '0) ? DRAIN : STREAM;
        end
        STREAM: begin
          acc_clr_n_o    <= 1'b1;
          redo_coeff_o   <= 1'b0;
          rd_en_signal_o <= fire;
          rd_en_coeff_o  <= fire;
          if (fire) begin
            count <= count_nxt;
            if (count_nxt == len_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          acc_clr_n_o    <= 1'b1;
          redo_coeff_o   <= 1'b0;
          rd_en_signal_o <= 1'b0;
          rd_en_coeff_o  <= 1'b0;
          if (drain_cnt == '0) state <= LOAD;
          else                 drain_cnt <= drain_cnt - DW'(1);
        end
        LOAD: begin
          ld_result_o <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          ld_result_o <= 1'b0;
          done_o      <= grant_o;
          grant_o     <= 2'b00;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_share_scheduler.md
Name: mac_share_scheduler

Overview:
- Time-shares one MAC (signal FIFO, coefficient FIFO, accumulate datapath) between two requesters.
- Round-robin arbitration picks a requester, then the block sequences one dot-product job: accumulator clear, coefficient-pointer rewind, N paired FIFO reads, pipeline drain, result load, done pulse.
- Sits between the requester front-ends and the MAC's FIFO read/redo controls and datapath clear/load strobes.

Parameters:
- ADDR_LINES, 4, FIFO address width; maximum job length is 2^ADDR_LINES.
- LEN_WIDTH, 5, width of the job-length inputs (ADDR_LINES+1).
- PIPE_LAT, 2, cycles from the last rd_en to the final product being accumulated.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  synchronous active-low reset.
- req_i  in  2  per-requester job request, level; held until the matching done_o.
- len0_i  in  LEN_WIDTH  job length for requester 0; sampled at grant.
- len1_i  in  LEN_WIDTH  job length for requester 1; sampled at grant.
- empty_signal_i  in  1  signal FIFO empty.
- empty_coeff_i  in  1  coefficient FIFO empty.
- grant_o  out  2  one-hot owner of the MAC for the whole job.
- busy_o  out  1  high in any state other than IDLE.
- rd_en_signal_o  out  1  signal FIFO read strobe.
- rd_en_coeff_o  out  1  coefficient FIFO read strobe.
- redo_coeff_o  out  1  one-cycle pulse that rewinds the coefficient read pointer to 0.
- acc_clr_n_o  out  1  active-low accumulator clear to the datapath.
- ld_result_o  out  1  one-cycle result-register load strobe.
- done_o  out  2  one-cycle completion pulse to the owning requester.

Behaviour:
- All outputs are registered.
- Reset values: grant_o=0, busy_o=0, rd_en_*=0, redo_coeff_o=0, acc_clr_n_o=0 (accumulator held clear during reset), ld_result_o=0, done_o=0, state=IDLE, last_grant=1, count=0.
- States are IDLE, CLEAR, STREAM, DRAIN, LOAD, DONE.
- IDLE:
  - acc_clr_n_o=1.
  - If req_i != 0, arbitrate. If only one requester is active, grant it. If both are active, grant the one that is not last_grant.
  - On grant: latch the owner's len, clamping values >2^ADDR_LINES to 2^ADDR_LINES. Update last_grant. Set grant_o. Go to CLEAR.
- CLEAR (exactly 1 cycle): acc_clr_n_o=0, redo_coeff_o=1, count=0. Next state is STREAM, or DRAIN if the latched len is 0.
- STREAM:
  - Each cycle, if count<len and both empties are 0, assert rd_en_signal_o and rd_en_coeff_o together and increment count.
  - If either FIFO is empty, both strobes stay 0 and count holds. This is a stall; there is no timeout.
  - The two strobes are never asserted independently.
  - When count reaches len (after the last read cycle), go to DRAIN.
- DRAIN: wait PIPE_LAT cycles with all strobes low, then go to LOAD.
- LOAD (1 cycle): ld_result_o=1.
- DONE (1 cycle): done_o[owner]=1, grant_o=0, busy_o deasserts next cycle, return to IDLE.
- Arbitration latency: from IDLE, the earliest next grant comes 1 cycle after DONE.
- Request handling:
  - Requests arriving mid-job wait in req_i; they are not queued internally.
  - Deasserting the owner's req_i mid-job is ignored; the job runs to completion and done_o still pulses.
  - A requester re-asserting immediately after its done loses to a waiting peer.
- Job latency with no stalls and len=N: grant to done_o = 1 (CLEAR) + N + PIPE_LAT + 1 (LOAD) + 1 cycles.
- count width is LEN_WIDTH; it never wraps because of the clamp.
- Reset asserted mid-job: on the next edge, all outputs take their reset values and state returns to IDLE. The partial result is discarded and no done_o is issued. FIFO pointer recovery is the FIFOs' own reset.

Test Plan:
- Single job: req_i=01, len0=4, FIFOs non-empty → grant_o=01 next cycle; redo_coeff_o and acc_clr_n_o=0 for 1 cycle; rd_en high 4 consecutive cycles; 2 idle cycles; ld_result_o 1 cycle; done_o=01 exactly 9 cycles after grant.
- Contention: req_i=11 from reset → requester 0 served first, then requester 1 (grant_o 01 then 10); hold req_i=11 → grants alternate 01,10,01.
- Stall: len1=3, toggle empty_coeff_i high for 2 cycles after the first read → rd_en low both cycles, exactly 3 read pulses total, done_o delayed by 2 cycles.
- len0=0 → CLEAR, 2-cycle DRAIN, ld_result_o, done_o; zero read strobes.
- len0=31 with ADDR_LINES=4 → exactly 16 read pulses.
- Reset pulse during STREAM after 2 reads → next cycle all outputs at reset values, acc_clr_n_o=0, no done_o; a fresh request then completes normally.
